sample_sequencer: RTL and testbench
===================================

# sample_sequencer

Paces the external sampling datapath and hands its captured words to the soft processor. It generates `sample_clk` at a programmable rate and captures the 64-bit `{in_h, in_l}` word once per period into a small FIFO. Entries are released to the processor's PIO ports through a four-phase request/valid handshake. The block sits between the Qsys system's sample-clock, in_h/in_l and out0/out1 PIOs and the external converter logic, replacing software-timed polling.

## Interface
- `DIV_WIDTH`, 16, width of the period register
- `FIFO_DEPTH`, 8, FIFO entries; power of two, ≥2
- `clk_clk` in 1: sole clock, rising-edge
- `reset_reset` in 1: synchronous, active-high reset
- `cfg_enable` in 1: run sampling when 1
- `cfg_period` in DIV_WIDTH: sample period P in clocks; values <4 treated as 4
- `cfg_clear` in 1: single-cycle pulse; flushes FIFO, clears `overflow`
- `in_h` in 32: upper data word from converter
- `in_l` in 32: lower data word from converter
- `sample_clk` out 1: converter sample clock
- `rd_req` in 1: processor request level (4-phase)
- `rd_valid` out 1: `rd_data_h`/`rd_data_l` valid
- `rd_data_h` out 32: upper word of presented entry
- `rd_data_l` out 32: lower word of presented entry
- `fifo_count` out $clog2(FIFO_DEPTH)+1: entries stored, excluding one being presented
- `overflow` out 1: sticky; a capture was dropped due to full FIFO

## Operation
- Phase counter `ph` counts 0..P-1, wraps to 0; runs only while `cfg_enable`=1. `cfg_period` is sampled at `ph`=P-1 (wrap), so changes take effect at the next period.
- `sample_clk` is registered: 1 when `ph` < P/2 (floor), else 0.
- Capture event: cycle where `ph` = P/2 (falling edge of `sample_clk`). `{in_h,in_l}` as sampled that cycle is pushed.
- `cfg_enable` 1→0: `ph` forced to 0 and `sample_clk` to 0 next cycle. FIFO contents and the handshake are unaffected. 0→1: period starts at `ph`=0 with `sample_clk` high.
- FIFO: circular, read/write pointers with an extra wrap bit. A push when full drops the word and sets `overflow`. Push and pop in the same cycle are both honoured, including when full (pop frees the slot first) and when empty (no bypass; the word is stored).
- Handshake FSM:
  - IDLE: if `rd_req`=1 and FIFO not empty → pop head into `rd_data_*`, go PRESENT.
  - PRESENT: `rd_valid`=1; data held stable; on `rd_req`=0 → go DROP.
  - DROP: `rd_valid`=0; return to IDLE next cycle. A new request is not served until IDLE.
  - `rd_req` held high while FIFO empty: wait in IDLE; serve as soon as an entry arrives.
- `cfg_clear`: resets pointers, `fifo_count`=0, `overflow`=0. The presented entry (PRESENT) completes normally. A capture in the same cycle as `cfg_clear` is discarded.

## Timing
- Reset values: `sample_clk`=0, `rd_valid`=0, `rd_data_h`=`rd_data_l`=0, `fifo_count`=0, `overflow`=0; FSM IDLE, `ph`=0. Reset mid-handshake abandons the entry.
- First `sample_clk` rise is 1 cycle after `cfg_enable` is seen high with `ph`=0.
- Capture latency: pushed word visible in `fifo_count` 1 cycle after the capture cycle.
- Request latency: `rd_req` rises in IDLE with non-empty FIFO → `rd_valid`=1 and data valid 1 cycle later. `fifo_count` decrements the same cycle.
- `rd_req` fall → `rd_valid`=0 next cycle. Minimum full handshake is 3 cycles.
- All outputs are registered; no combinational input→output path.

## Test plan
- P=10, enable for 50 cycles, in_h/in_l = cycle count → 5 `sample_clk` pulses, each high 5 cycles, low 5. Captures are at `ph`=5 and carry the values present on those cycles; `fifo_count`=5.
- Run with no reads for 9 periods, FIFO_DEPTH=8 → `fifo_count`=8 and `overflow`=1. Draining yields the first 8 samples in order; the 9th is absent.
- `rd_req` held high with FIFO empty, then one capture → `rd_valid` 2 cycles after the capture cycle with the captured value; `fifo_count` returns to 0.
- FIFO full, handshake pop coincides with a capture → no overflow; `fifo_count` stays 8; order is preserved.
- `cfg_clear` during PRESENT with 3 entries stored → current data is held until `rd_req` falls; `fifo_count`=0; the next request waits for a fresh capture.
- Change `cfg_period` 10→4 mid-period, then deassert `cfg_enable` at `ph`=2 → the current period finishes at 10 and the next at 4. `sample_clk`=0 and `ph`=0 one cycle after the disable.

Source files
------------

// File: rtl/sample_sequencer_if.sv
// sample_sequencer_if: processor read port of the sample sequencer.
// Four-phase request/valid handshake carrying one 64-bit FIFO entry.
interface sample_sequencer_if;
   logic        rd_req;
   logic        rd_valid;
   logic [31:0] rd_data_h;
   logic [31:0] rd_data_l;

   modport master (
      output rd_req,
      input  rd_valid,
      input  rd_data_h,
      input  rd_data_l
   );

   modport slave (
      input  rd_req,
      output rd_valid,
      output rd_data_h,
      output rd_data_l
   );
endinterface

// File: rtl/sample_sequencer.sv
// sample_sequencer: paces sample_clk, captures {in_h,in_l} once per period
// into a FIFO and releases entries over a four-phase req/valid handshake.
module sample_sequencer #(
   parameter int DIV_WIDTH  = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset,
   input  logic                         cfg_enable,
   input  logic [DIV_WIDTH-1:0]         cfg_period,
   input  logic                         cfg_clear,
   input  logic [31:0]                  in_h,
   input  logic [31:0]                  in_l,
   output logic                         sample_clk,
   sample_sequencer_if.slave            rd,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      DROP
   } hs_state_t;

   logic [DIV_WIDTH-1:0] ph;
   logic [DIV_WIDTH-1:0] period_q;
   logic [DIV_WIDTH-1:0] period_in;
   logic [DIV_WIDTH-1:0] half;
   logic                 capture;

   assign period_in = (cfg_period < DIV_WIDTH'(4)) ? DIV_WIDTH'(4)
                                                   : cfg_period;
   assign half      = period_q >> 1;
   assign capture   = cfg_enable && (ph == half);

   // period_q only reloads at a wrap or while idle, so a new
   // cfg_period never stretches or truncates a running period.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         ph         <= '0;
         period_q   <= period_in;
         sample_clk <= 1'b0;
      end else if (!cfg_enable) begin
         ph         <= '0;
         period_q   <= period_in;
         sample_clk <= 1'b0;
      end else begin
         sample_clk <= (ph < half);
         if (ph == period_q - DIV_WIDTH'(1)) begin
            ph       <= '0;
            period_q <= period_in;
         end else begin
            ph <= ph + DIV_WIDTH'(1);
         end
      end
   end

   logic [63:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic        wr_en;

   assign empty = (fifo_count == '0);
   assign full  = (fifo_count == FULL_CNT);
   assign push  = capture && !cfg_clear;
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk_clk) begin
      if (reset_reset || cfg_clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
         fifo_count <= fifo_count + (AW+1)'(wr_en) - (AW+1)'(pop);
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {in_h, in_l};
   end

   hs_state_t state;
   hs_state_t state_n;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) state <= IDLE;
      else             state <= state_n;
   end

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            if (rd.rd_req && !empty) begin
               pop     = 1'b1;
               state_n = PRESENT;
            end
         end
         PRESENT: begin
            if (!rd.rd_req) state_n = DROP;
         end
         DROP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // A full-FIFO pop reads the slot before the same-cycle write lands.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         rd.rd_valid  <= 1'b0;
         rd.rd_data_h <= '0;
         rd.rd_data_l <= '0;
      end else begin
         rd.rd_valid <= (state_n == PRESENT);
         if (pop) begin
            {rd.rd_data_h, rd.rd_data_l} <= mem[rd_ptr[AW-1:0]];
         end
      end
   end
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: directed test-plan steps plus a random phase,
// checked against a queue-based behavioural model.
module tb_sample_sequencer;
   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk_clk = 1'b0;
   logic          reset_reset;
   logic          cfg_enable;
   logic [DW-1:0] cfg_period;
   logic          cfg_clear;
   logic [31:0]   in_h;
   logic [31:0]   in_l;
   logic          sample_clk;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   sample_sequencer_if rd ();

   sample_sequencer #(
      .DIV_WIDTH  (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .cfg_enable  (cfg_enable),
      .cfg_period  (cfg_period),
      .cfg_clear   (cfg_clear),
      .in_h        (in_h),
      .in_l        (in_l),
      .sample_clk  (sample_clk),
      .rd          (rd),
      .fifo_count  (fifo_count),
      .overflow    (overflow)
   );

   always #5 clk_clk = ~clk_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rises = 0;
   int hi_cnt = 0;
   int rise_cyc[$];
   bit prev_sclk = 1'b0;

   // Model state: position inside the current period, its length,
   // the stored words and the handshake phase.
   int          m_pos;
   int          m_len;
   bit          m_sclk;
   bit          m_ovf;
   int          m_hs;
   logic [63:0] m_data;
   logic [63:0] m_q[$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_period(input int p);
      return (p < 4) ? 4 : p;
   endfunction

   task automatic model_eval();
      int  p_in;
      bit  cap;
      p_in = eff_period(int'(cfg_period));
      if (reset_reset) begin
         m_pos  = 0;
         m_len  = p_in;
         m_sclk = 0;
         m_ovf  = 0;
         m_hs   = 0;
         m_data = '0;
         m_q.delete();
         return;
      end
      cap = cfg_enable && (m_pos == m_len / 2);
      if (m_hs == 0) begin
         if (rd.rd_req && m_q.size() > 0) begin
            m_data = m_q.pop_front();
            m_hs   = 1;
         end
      end else if (m_hs == 1) begin
         if (!rd.rd_req) m_hs = 2;
      end else begin
         m_hs = 0;
      end
      if (cfg_clear) begin
         m_q.delete();
         m_ovf = 0;
      end else if (cap) begin
         if (m_q.size() < DEPTH) m_q.push_back({in_h, in_l});
         else m_ovf = 1;
      end
      if (!cfg_enable) begin
         m_sclk = 0;
         m_pos  = 0;
         m_len  = p_in;
      end else begin
         m_sclk = (m_pos < m_len / 2);
         m_pos  = m_pos + 1;
         if (m_pos == m_len) begin
            m_pos = 0;
            m_len = p_in;
         end
      end
   endtask

   task automatic step();
      in_h = 32'(cyc);
      in_l = $urandom();
      model_eval();
      @(posedge clk_clk);
      #1;
      cyc++;
      chk("sample_clk", 64'(sample_clk), 64'(m_sclk));
      chk("rd_valid", 64'(rd.rd_valid), 64'(m_hs == 1));
      chk("rd_data", {rd.rd_data_h, rd.rd_data_l}, m_data);
      chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (sample_clk && !prev_sclk) begin
         rises++;
         rise_cyc.push_back(cyc);
      end
      if (sample_clk) hi_cnt++;
      prev_sclk = sample_clk;
   endtask

   task automatic wait_valid(input bit want, input int lim);
      int k = 0;
      while (rd.rd_valid !== want && k < lim) begin
         step();
         k++;
      end
      chk("wait_valid", 64'(rd.rd_valid), 64'(want));
   endtask

   task automatic read_one();
      rd.rd_req = 1'b1;
      wait_valid(1'b1, 300);
      rd.rd_req = 1'b0;
      step();
      step();
   endtask

   task automatic pulse_clear();
      cfg_clear = 1'b1;
      step();
      cfg_clear = 1'b0;
   endtask

   initial begin
      int e;
      int e2;
      int k;
      reset_reset = 1'b1;
      cfg_enable  = 1'b0;
      cfg_period  = DW'(10);
      cfg_clear   = 1'b0;
      rd.rd_req   = 1'b0;
      in_h        = '0;
      in_l        = '0;
      step();
      step();
      chk("rst_sclk", 64'(sample_clk), 64'(0));
      chk("rst_valid", 64'(rd.rd_valid), 64'(0));
      chk("rst_data", {rd.rd_data_h, rd.rd_data_l}, 64'(0));
      chk("rst_count", 64'(fifo_count), 64'(0));
      chk("rst_ovf", 64'(overflow), 64'(0));
      reset_reset = 1'b0;
      step();

      // P=10 for 50 cycles
      rises = 0;
      hi_cnt = 0;
      rise_cyc.delete();
      cfg_enable = 1'b1;
      e = cyc;
      repeat (50) step();
      cfg_enable = 1'b0;
      step();
      chk("t1_rises", 64'(rises), 64'(5));
      chk("t1_high", 64'(hi_cnt), 64'(25));
      chk("t1_first_rise", 64'(rise_cyc[0]), 64'(e + 1));
      chk("t1_spacing", 64'(rise_cyc[1] - rise_cyc[0]), 64'(10));
      chk("t1_count", 64'(fifo_count), 64'(5));
      read_one();
      chk("t1_first_cap", 64'(rd.rd_data_h), 64'(e + 5));

      // overflow after nine periods without reads
      pulse_clear();
      cfg_enable = 1'b1;
      e = cyc;
      repeat (90) step();
      cfg_enable = 1'b0;
      step();
      chk("t2_count", 64'(fifo_count), 64'(8));
      chk("t2_ovf", 64'(overflow), 64'(1));
      for (int i = 0; i < 8; i++) begin
         read_one();
         chk("t2_order", 64'(rd.rd_data_h), 64'(e + 5 + 10 * i));
      end
      chk("t2_drained", 64'(fifo_count), 64'(0));

      // request held over an empty FIFO
      pulse_clear();
      chk("t3_ovf_clr", 64'(overflow), 64'(0));
      rd.rd_req = 1'b1;
      cfg_enable = 1'b1;
      e = cyc;
      wait_valid(1'b1, 40);
      chk("t3_latency", 64'(cyc), 64'(e + 7));
      chk("t3_data", 64'(rd.rd_data_h), 64'(e + 5));
      cfg_enable = 1'b0;
      rd.rd_req = 1'b0;
      step();
      step();
      chk("t3_count", 64'(fifo_count), 64'(0));

      // full FIFO: pop coincides with a capture
      cfg_enable = 1'b1;
      e = cyc;
      repeat (85) step();
      chk("t4_full", 64'(fifo_count), 64'(8));
      rd.rd_req = 1'b1;
      step();
      cfg_enable = 1'b0;
      chk("t4_ovf", 64'(overflow), 64'(0));
      chk("t4_count", 64'(fifo_count), 64'(8));
      chk("t4_pop", 64'(rd.rd_data_h), 64'(e + 5));
      rd.rd_req = 1'b0;
      step();
      step();
      for (int i = 0; i < 8; i++) begin
         read_one();
         chk("t4_order", 64'(rd.rd_data_h), 64'(e + 15 + 10 * i));
      end

      // clear while presenting
      cfg_enable = 1'b1;
      e = cyc;
      repeat (40) step();
      cfg_enable = 1'b0;
      step();
      rd.rd_req = 1'b1;
      wait_valid(1'b1, 10);
      chk("t5_count3", 64'(fifo_count), 64'(3));
      pulse_clear();
      chk("t5_count0", 64'(fifo_count), 64'(0));
      repeat (3) step();
      chk("t5_hold_v", 64'(rd.rd_valid), 64'(1));
      chk("t5_hold_d", 64'(rd.rd_data_h), 64'(e + 5));
      rd.rd_req = 1'b0;
      step();
      step();
      rd.rd_req = 1'b1;
      repeat (20) step();
      chk("t5_wait", 64'(rd.rd_valid), 64'(0));
      cfg_enable = 1'b1;
      e2 = cyc;
      wait_valid(1'b1, 40);
      chk("t5_fresh_t", 64'(cyc), 64'(e2 + 7));
      chk("t5_fresh_d", 64'(rd.rd_data_h), 64'(e2 + 5));
      cfg_enable = 1'b0;
      rd.rd_req = 1'b0;
      step();
      step();

      // period change 10 -> 4 mid-period, then disable at ph=2
      rises = 0;
      rise_cyc.delete();
      cfg_period = DW'(10);
      step();
      cfg_enable = 1'b1;
      repeat (3) step();
      cfg_period = DW'(4);
      k = 0;
      while (rises < 3 && k < 40) begin
         step();
         k++;
      end
      chk("t6_rises", 64'(rises), 64'(3));
      chk("t6_p10", 64'(rise_cyc[1] - rise_cyc[0]), 64'(10));
      chk("t6_p4", 64'(rise_cyc[2] - rise_cyc[1]), 64'(4));
      step();
      cfg_enable = 1'b0;
      step();
      chk("t6_off", 64'(sample_clk), 64'(0));
      cfg_enable = 1'b1;
      step();
      chk("t6_restart", 64'(sample_clk), 64'(1));
      cfg_enable = 1'b0;
      step();
      pulse_clear();

      // random phase
      cfg_enable = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 49) == 0) cfg_enable = ~cfg_enable;
         if ($urandom_range(0, 99) == 0)
            cfg_period = DW'($urandom_range(0, 13));
         cfg_clear = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 5) == 0) rd.rd_req = ~rd.rd_req;
         reset_reset = ($urandom_range(0, 499) == 0);
         step();
      end
      reset_reset = 1'b0;
      cfg_clear = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
